// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and FSM encoding for the fetch unit.
// Imported by fetch_unit and fetch_pc.
package fetch_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  function automatic logic is_busy(input logic [2:0] s);
    return (s != S_IDLE) && (s != S_HALTED);
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter register with clear, wrapping increment
// and load; pc_nxt exposes the value it takes at the next edge.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              ld,
  input  logic              inc,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc;
    unique case (1'b1)
      clr:     pc_nxt = '0;
      ld:      pc_nxt = ld_addr;
      inc:     pc_nxt = pc + ADDR_W'(1);
      default: pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) pc <= '0;
    else      pc <= pc_nxt;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: loads program bytes into prog_mem and fetches them one
// at a time to the decoder with a valid/ready hold and halt control.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              halt,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_enable,
  output logic              mem_wr_enable,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  logic [2:0]        state, state_d;
  logic [ADDR_W-1:0] load_ptr, wr_addr, pc_nxt;
  logic in_idle, in_fetch, hs, stop;
  logic rd_go, wr_go, pc_clr, pc_ld, pc_inc;

  assign in_idle  = state == S_IDLE;
  assign in_fetch = (state == S_REQ) || (state == S_WAIT)
                 || (state == S_HOLD);
  // halt outranks the handshake, so a halted HOLD never advances pc
  assign hs       = (state == S_HOLD) && instr_ready && !halt;
  assign stop     = in_fetch && halt;
  assign pc_clr   = in_idle && !load_en && start;
  assign pc_ld    = hs && jump_en;
  assign pc_inc   = hs && !jump_en;
  assign rd_go    = pc_clr || hs
                 || ((state == S_HALTED) && start);
  assign wr_go    = (in_idle || (state == S_LOAD)) && load_en;
  assign wr_addr  = in_idle ? '0 : load_ptr;

  fetch_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (pc_clr),
    .ld     (pc_ld),
    .inc    (pc_inc),
    .ld_addr(jump_addr),
    .pc     (pc),
    .pc_nxt (pc_nxt)
  );

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (load_en)    state_d = S_LOAD;
        else if (start) state_d = S_REQ;
      end
      S_LOAD:   if (!load_en) state_d = S_IDLE;
      S_REQ:    state_d = halt ? S_HALTED : S_WAIT;
      S_WAIT:   state_d = halt ? S_HALTED : S_HOLD;
      S_HOLD: begin
        if (halt)             state_d = S_HALTED;
        else if (instr_ready) state_d = S_REQ;
      end
      S_HALTED: if (start) state_d = S_REQ;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state         <= S_IDLE;
      load_ptr      <= '0;
      instr         <= '0;
      instr_valid   <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      mem_rd_enable <= 1'b0;
      mem_wr_enable <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      busy          <= is_busy(state_d);
      mem_rd_enable <= rd_go;
      mem_wr_enable <= wr_go;
      if (rd_go) begin
        mem_addr <= pc_nxt;
      end else if (wr_go) begin
        mem_addr    <= wr_addr;
        mem_wr_data <= load_data;
        load_ptr    <= wr_addr + ADDR_W'(1);
      end
      if ((state == S_WAIT) && !halt) begin
        instr       <= mem_rd_data;
        instr_valid <= 1'b1;
      end else if (stop || hs) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a
// transaction-level model of the fetch unit and a prog_mem model.
module tb_fetch_unit;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  localparam int M_IDLE   = 0;
  localparam int M_LOAD   = 1;
  localparam int M_FETCH  = 2;
  localparam int M_HALTED = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, start, halt, load_en, jump_en;
  logic          instr_ready;
  logic [DW-1:0] load_data, mem_rd_data, mem_wr_data, instr;
  logic [AW-1:0] jump_addr, mem_addr, pc;
  logic          mem_rd_enable, mem_wr_enable;
  logic          instr_valid, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic preload_req;

  logic [DW-1:0]    pmem [DEPTH];
  int               ref_mem [DEPTH];
  logic [AW+DW-1:0] wlog [$];
  logic [AW-1:0]    rlog [$];
  logic [DW-1:0]    hlog [$];

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .halt         (halt),
    .load_en      (load_en),
    .load_data    (load_data),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .mem_addr     (mem_addr),
    .mem_rd_enable(mem_rd_enable),
    .mem_wr_enable(mem_wr_enable),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc           (pc),
    .busy         (busy)
  );

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // prog_mem: synchronous read, data valid the cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload_req)
      for (int i = 0; i < DEPTH; i++) pmem[i] <= DW'(16 + i);
    if (mem_wr_enable) begin
      pmem[mem_addr] <= mem_wr_data;
      wlog.push_back({mem_addr, mem_wr_data});
    end
    if (mem_rd_enable) begin
      mem_rd_data <= pmem[mem_addr];
      rlog.push_back(mem_addr);
    end
    if (!rstn && instr_valid && instr_ready && !halt)
      hlog.push_back(instr);
  end

  // reference model: what the outputs must be after each edge
  int m_mode, m_phase, m_pc, m_ptr, m_addr, m_wdata, m_instr;
  bit m_rd, m_wr, m_valid;

  always @(posedge clk) begin
    if (preload_req)
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16 + i;
    if (rstn) begin
      m_mode = M_IDLE; m_phase = 0; m_pc = 0; m_ptr = 0;
      m_addr = 0; m_wdata = 0; m_instr = 0;
      m_rd = 0; m_wr = 0; m_valid = 0;
    end else begin
      m_rd = 0;
      m_wr = 0;
      case (m_mode)
        M_IDLE: begin
          if (load_en) begin
            m_mode = M_LOAD;
            m_ptr = 0;
          end else if (start) begin
            m_pc = 0;
            m_mode = M_FETCH; m_phase = 0;
            m_rd = 1; m_addr = m_pc;
          end
        end
        M_LOAD: if (!load_en) m_mode = M_IDLE;
        M_FETCH: begin
          if (halt) begin
            m_mode = M_HALTED;
            m_valid = 0;
          end else if (m_phase == 0) begin
            m_phase = 1;
          end else if (m_phase == 1) begin
            m_instr = ref_mem[m_pc];
            m_valid = 1;
            m_phase = 2;
          end else if (instr_ready) begin
            m_pc = jump_en ? int'(jump_addr) : (m_pc + 1) % DEPTH;
            m_valid = 0;
            m_phase = 0;
            m_rd = 1; m_addr = m_pc;
          end
        end
        default: begin
          if (start) begin
            m_mode = M_FETCH; m_phase = 0;
            m_rd = 1; m_addr = m_pc;
          end
        end
      endcase
      if (m_mode == M_LOAD && load_en) begin
        m_wr = 1;
        m_addr = m_ptr;
        m_wdata = int'(load_data);
        ref_mem[m_ptr] = m_wdata;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("pc", int'(pc), m_pc);
    check("busy", int'(busy),
          int'(m_mode == M_LOAD || m_mode == M_FETCH));
    check("instr_valid", int'(instr_valid), int'(m_valid));
    check("instr", int'(instr), m_instr);
    check("mem_rd_enable", int'(mem_rd_enable), int'(m_rd));
    check("mem_wr_enable", int'(mem_wr_enable), int'(m_wr));
    check("mem_addr", int'(mem_addr), m_addr);
    check("mem_wr_data", int'(mem_wr_data), m_wdata);
    check("rd_wr_exclusive",
          int'(mem_rd_enable & mem_wr_enable), 0);
  end

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) check("wait_valid_timeout", 0, 1);
  endtask

  task automatic last_read(string name, int exp);
    check(name, (rlog.size() > 0) ? int'(rlog[$]) : -1, exp);
  endtask

  int t0, rs, ws, n;
  int ld_vals [4] = '{89, 46, 23, 7};

  initial begin
    rstn = 1; start = 0; halt = 0; load_en = 0;
    load_data = '0; jump_en = 0; jump_addr = '0;
    instr_ready = 0; preload_req = 1;
    repeat (2) @(negedge clk);
    preload_req = 0;
    check("reset_pc", int'(pc), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(instr_valid), 0);
    rstn = 0;
    @(negedge clk);

    // fetch with latency and in-order stream
    start = 1; t0 = cyc;
    @(negedge clk);
    start = 0;
    wait_valid();
    check("start_latency", cyc - t0, 3);
    instr_ready = 1;
    n = 0;
    while (hlog.size() < 3 && n < 30) begin
      @(negedge clk);
      n++;
    end
    instr_ready = 0;
    check("stream_count", hlog.size(), 3);
    for (int i = 0; i < 3; i++)
      check("stream_instr",
            (hlog.size() > i) ? int'(hlog[i]) : -1, 16 + i);

    // backpressure
    wait_valid();
    rs = rlog.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", int'(instr_valid), 1);
      check("bp_instr", int'(instr), 8'h13);
      check("bp_pc", int'(pc), 3);
    end
    check("bp_no_read", rlog.size() - rs, 0);

    // jump to 5
    jump_en = 1; jump_addr = 4'd5; instr_ready = 1;
    @(negedge clk);
    jump_en = 0; instr_ready = 0; jump_addr = '0;
    wait_valid();
    last_read("jump5_addr", 5);
    check("jump5_instr", int'(instr), 8'h15);
    check("jump5_pc", int'(pc), 5);

    // jump to 15 then wrap to 0
    jump_en = 1; jump_addr = 4'd15; instr_ready = 1;
    @(negedge clk);
    jump_en = 0; instr_ready = 0; jump_addr = '0;
    wait_valid();
    check("jump15_instr", int'(instr), 8'h1F);
    instr_ready = 1;
    @(negedge clk);
    instr_ready = 0;
    wait_valid();
    last_read("wrap_addr", 0);
    check("wrap_instr", int'(instr), 8'h10);
    check("wrap_pc", int'(pc), 0);

    // halt in WAIT, then resume
    instr_ready = 1;
    @(negedge clk);
    instr_ready = 0;
    @(negedge clk);
    halt = 1;
    @(negedge clk);
    halt = 0;
    check("halt_valid", int'(instr_valid), 0);
    check("halt_busy", int'(busy), 0);
    check("halt_pc", int'(pc), 1);
    rs = rlog.size();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_valid();
    check("resume_reads", rlog.size() - rs, 1);
    last_read("resume_addr", 1);
    check("resume_instr", int'(instr), 8'h11);

    rstn = 1;
    @(negedge clk);
    rstn = 0;

    // program load
    ws = wlog.size();
    rs = rlog.size();
    for (int i = 0; i < 4; i++) begin
      load_en = 1;
      load_data = DW'(ld_vals[i]);
      @(negedge clk);
    end
    load_en = 0;
    repeat (3) @(negedge clk);
    check("load_count", wlog.size() - ws, 4);
    for (int i = 0; i < 4; i++) begin
      check("load_addr", (wlog.size() > ws + i) ?
            int'(wlog[ws + i][AW+DW-1:DW]) : -1, i);
      check("load_data", (wlog.size() > ws + i) ?
            int'(wlog[ws + i][DW-1:0]) : -1, ld_vals[i]);
    end
    check("load_no_read", rlog.size() - rs, 0);

    // reset in the middle of a load
    ws = wlog.size();
    load_en = 1; load_data = 8'hA1;
    @(negedge clk);
    load_data = 8'hA2;
    @(negedge clk);
    load_data = 8'hA3; rstn = 1;
    @(negedge clk);
    rstn = 0; load_en = 0;
    repeat (3) @(negedge clk);
    check("rst_load_count", wlog.size() - ws, 2);
    check("rst_load_busy", int'(busy), 0);
    ws = wlog.size();
    load_en = 1; load_data = 8'h33;
    @(negedge clk);
    load_en = 0;
    repeat (2) @(negedge clk);
    check("reload_count", wlog.size() - ws, 1);
    check("reload_addr", (wlog.size() > ws) ?
          int'(wlog[ws][AW+DW-1:DW]) : -1, 0);
    check("reload_data", (wlog.size() > ws) ?
          int'(wlog[ws][DW-1:0]) : -1, 8'h33);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rstn        = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 3) == 0);
      halt        = ($urandom_range(0, 11) == 0);
      load_en     = ($urandom_range(0, 5) == 0);
      load_data   = DW'($urandom);
      jump_en     = $urandom_range(0, 1) == 1;
      jump_addr   = AW'($urandom);
      instr_ready = $urandom_range(0, 1) == 1;
      @(negedge clk);
    end
    rstn = 0; start = 0; halt = 0; load_en = 0;
    jump_en = 0; instr_ready = 0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
